quad_dec: RTL and testbench
===========================

QUAD_DEC -- requirements
Module: quad_dec

Interface
REQ-001 Parameter WIDTH, default 10, SHALL set the width of position.
REQ-002 Parameter FILTER, default 2, legal range 1..15, SHALL set the number of consecutive stable cycles the input filter requires.
REQ-003 Parameter RESET_POS, default 0, SHALL set the reset and clear value of position.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 enable  input  1  SHALL be the synchronous count enable, active-high.
REQ-007 clear  input  1  SHALL be the synchronous clear of position and err, active-high.
REQ-008 a_in, b_in  input  1 each  SHALL be the asynchronous quadrature channels.
REQ-009 position  output  WIDTH  SHALL be the registered step count.
REQ-010 dir  output  1  SHALL be the direction of the last counted step: 0 ascending, 1 descending.
REQ-011 step  output  1  SHALL be a one-cycle pulse, high in the cycle after each counted step.
REQ-012 err  output  1  SHALL be the sticky illegal-transition flag.

Function
REQ-013 {a_in,b_in} SHALL pass through a 2-flop synchronizer: sync1 captures at edge 1 and sync2 at edge 2, where edge 1 is the first edge that samples the new level.
REQ-014 The 2-bit filtered value SHALL take sync2 once sync2 differs from filtered and holds one value for FILTER consecutive edges; any change in sync2 restarts the stability count.
REQ-015 prev SHALL hold the last decoded {A,B}; the decode of (prev, filtered) SHALL update outputs, and prev <= filtered, on edge FILTER+3.
REQ-016 Forward sequence 00->01->11->10->00 SHALL increment position and set dir=0; the reverse sequence SHALL decrement it and set dir=1.
REQ-017 A transition that changes both bits SHALL set err=1 and leave position, dir and step unchanged.
REQ-018 When prev equals filtered, position, dir and step SHALL hold, and step SHALL be 0.
REQ-019 Arithmetic SHALL be modulo 2^WIDTH: the maximum value plus one is 0, and 0 minus one is the maximum value.
REQ-020 When enable=0, position, dir and step SHALL hold, and err SHALL not set; synchronizer, filter and prev SHALL keep tracking so that re-enabling produces no spurious step.
REQ-021 When clear=1, position SHALL take RESET_POS and err SHALL take 0 at the next edge, overriding any step or error in the same cycle; step SHALL be 0 and prev SHALL still update.
REQ-022 Latency from a legal input edge to the position change SHALL be FILTER+3 edges (5 at the default), and step SHALL be high in the same cycle position changes.
REQ-023 A pulse on a_in or b_in shorter than FILTER cycles after synchronization SHALL produce no filtered change.

Reset
REQ-024 While rst=1, immediately and independently of clk, position=RESET_POS, dir=0, step=0, err=0, the synchronizers and filtered=00, prev=00, and the stability count and armed=0 SHALL be asserted.
REQ-025 After reset release, the first stable filtered value (FILTER edges after sync2 settles) SHALL load both filtered and prev, and SHALL set armed=1 with no step and no err.
REQ-026 Decode, step and err SHALL be inhibited while armed=0.
REQ-027 rst asserted mid-sequence SHALL discard all pending filter and decode state.

Verification
REQ-028 Reset with inputs at 00, then apply 01,11,10,00, each held 8 cycles, with enable=1 -> position counts 1,2,3,4; dir=0; four step pulses, each 5 edges after its input change.
REQ-029 From position=0, apply the reverse sequence 10 for 8 cycles -> position=1023, dir=1, err=0.
REQ-030 Hold inputs at 01, then apply a 1-cycle glitch to 00 and back -> no step and position unchanged; repeat with 00->11 held 8 cycles -> err=1 and position unchanged.
REQ-031 Set enable=0, apply two forward steps, then set enable=1 -> position unchanged and no step on re-enable; the next forward step increments by exactly 1.
REQ-032 Assert clear in the same cycle a step decodes -> position=RESET_POS, err=0, step=0; assert rst mid-filter -> all outputs reach reset values without a clk edge.
REQ-033 Release reset with inputs at 11 -> armed is set after FILTER+2 edges with no err and no step; a following 11->10 transition -> position=1.

Source files
------------

// File: rtl/quad_dec_if.sv
// Quadrature decoder bus: encoder channels and controls toward the decoder,
// count, direction and status back toward the consumer.
interface quad_dec_if #(
  parameter int WIDTH = 10
);
  // No valid/ready handshake: enable and clear are levels sampled on every
  // rising edge, and step is a one-cycle strobe that the consumer must not stall.
  logic             enable;
  logic             clear;
  logic             a_in;
  logic             b_in;
  logic [WIDTH-1:0] position;
  logic             dir;
  logic             step;
  logic             err;
  logic             armed;
  logic [1:0]       dbg_state;

  modport master (
    output enable, clear, a_in, b_in,
    input  position, dir, step, err, armed, dbg_state
  );

  modport slave (
    input  enable, clear, a_in, b_in,
    output position, dir, step, err, armed, dbg_state
  );
endinterface

// File: rtl/quad_dec.sv
// Quadrature decoder: 2-flop synchronizer, stability filter, Gray-step decode
// into a wrapping position counter with direction, step strobe and sticky error.
module quad_dec #(
  parameter int WIDTH     = 10,
  parameter int FILTER    = 2,
  parameter int RESET_POS = 0
) (
  input  logic      clk,
  input  logic      rst,
  quad_dec_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FILL0 = 2'd0,
    ST_FILL1 = 2'd1,
    ST_ACQ   = 2'd2,
    ST_TRACK = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] RST_POS = WIDTH'(RESET_POS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [3:0]       FILT_N  = 4'(FILTER);

  state_t           state_q, state_d;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       filt_q, filt_d;
  logic [1:0]       prev_q, prev_d;
  logic [WIDTH-1:0] position_q, position_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  logic [3:0]       cnt_inc;
  logic [1:0]       g_prev;
  logic [1:0]       g_filt;
  logic [1:0]       g_delta;

  // Position of an {A,B} code along the forward cycle 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] v);
    return {v[1], v[1] ^ v[0]};
  endfunction

  always_comb begin
    sync1_d    = {bus.a_in, bus.b_in};
    sync2_d    = sync1_q;
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    filt_d     = filt_q;
    prev_d     = prev_q;
    position_d = position_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    err_d      = err_q;
    cnt_inc    = cnt_q + 4'd1;
    g_prev     = gray_idx(prev_q);
    g_filt     = gray_idx(filt_q);
    g_delta    = g_filt - g_prev;

    // FILL states wait for sync2 to hold a real sample; ACQ filters without a
    // reference so the first stable value seeds both filt and prev.
    case (state_q)
      ST_FILL0: state_d = ST_FILL1;
      ST_FILL1: state_d = ST_ACQ;
      default: begin
        if (state_q == ST_TRACK && sync2_q == filt_q) begin
          cnt_d = 4'd0;
        end else begin
          if (sync2_q == cand_q && cnt_q != 4'd0) begin
            cnt_d = cnt_inc;
          end else begin
            cand_d = sync2_q;
            cnt_d  = 4'd1;
          end
          if (cnt_d >= FILT_N) begin
            cnt_d  = 4'd0;
            filt_d = sync2_q;
            if (state_q == ST_ACQ) begin
              prev_d  = sync2_q;
              state_d = ST_TRACK;
            end
          end
        end
      end
    endcase

    // prev follows filt even when disabled so re-enabling cannot replay a step.
    if (state_q == ST_TRACK) begin
      prev_d = filt_q;
      if (bus.enable) begin
        case (g_delta)
          2'd1: begin
            position_d = position_q + ONE;
            dir_d      = 1'b0;
            step_d     = 1'b1;
          end
          2'd3: begin
            position_d = position_q - ONE;
            dir_d      = 1'b1;
            step_d     = 1'b1;
          end
          2'd2:    err_d = 1'b1;
          default: ;
        endcase
      end
    end

    if (bus.clear) begin
      position_d = RST_POS;
      err_d      = 1'b0;
      step_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FILL0;
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      cand_q     <= 2'b00;
      cnt_q      <= 4'd0;
      filt_q     <= 2'b00;
      prev_q     <= 2'b00;
      position_q <= RST_POS;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      position_q <= position_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  assign bus.position  = position_q;
  assign bus.dir       = dir_q;
  assign bus.step      = step_q;
  assign bus.err       = err_q;
  assign bus.armed     = (state_q == ST_TRACK);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_quad_dec.sv
// Self-checking bench for quad_dec: directed scenarios with fixed expectations
// plus randomized encoder traffic compared against a history-window model.
module tb_quad_dec;
  localparam int WIDTH     = 10;
  localparam int FILTER    = 2;
  localparam int RESET_POS = 0;
  localparam int MODV      = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  quad_dec_if #(.WIDTH(WIDTH)) bus();

  quad_dec #(.WIDTH(WIDTH), .FILTER(FILTER), .RESET_POS(RESET_POS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, advanced once per rising edge.
  logic [1:0] smp_q[$];
  int         m_pos;
  logic       m_dir, m_step, m_err, m_armed;
  logic [1:0] m_prev, m_filt;

  function automatic int seq_idx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    smp_q.delete();
    m_pos = RESET_POS; m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0;
    m_armed = 1'b0; m_prev = 2'b00; m_filt = 2'b00;
  endtask

  // The filtered value changes once the last FILTER synchronized samples agree;
  // a synchronized sample at edge n is the input captured two edges earlier.
  task automatic model_edge();
    int n, d;
    logic ok;
    logic [1:0] v, nf, np;
    logic na;
    smp_q.push_back({bus.a_in, bus.b_in});
    n = smp_q.size();
    nf = m_filt; np = m_prev; na = m_armed;
    m_step = 1'b0;
    if (m_armed) begin
      np = m_filt;
      d = (seq_idx(m_filt) - seq_idx(m_prev) + 4) % 4;
      if (bus.enable) begin
        if (d == 1) begin m_pos = (m_pos + 1) % MODV; m_dir = 1'b0; m_step = 1'b1; end
        else if (d == 3) begin m_pos = (m_pos + MODV - 1) % MODV; m_dir = 1'b1; m_step = 1'b1; end
        else if (d == 2) m_err = 1'b1;
      end
    end
    if (bus.clear) begin m_pos = RESET_POS; m_err = 1'b0; m_step = 1'b0; end
    if (n >= FILTER + 2) begin
      v = smp_q[n-3];
      ok = 1'b1;
      for (int i = n - FILTER - 2; i <= n - 3; i++) if (smp_q[i] !== v) ok = 1'b0;
      if (ok && (!m_armed || v != m_filt)) begin
        nf = v;
        if (!m_armed) begin np = v; na = 1'b1; end
      end
    end
    m_filt = nf; m_prev = np; m_armed = na;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] v);
    bus.a_in = v[1];
    bus.b_in = v[0];
  endtask

  task automatic hold(input int n, output int steps);
    steps = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (bus.step === 1'b1) steps++;
    end
  endtask

  task automatic do_reset(input logic [1:0] ab);
    rst = 1'b1;
    model_reset();
    set_ab(ab);
    bus.enable = 1'b1;
    bus.clear  = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'b00);
    rst = 1'b1;
    repeat (2) cycle();
    n_cmp++; if (bus.position !== WIDTH'(RESET_POS)) begin n_bad++; $display("FAIL reset_position: got %0d expected %0d", bus.position, RESET_POS); end
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir: got %b expected 0", bus.dir); end
    n_cmp++; if (bus.step !== 1'b0) begin n_bad++; $display("FAIL reset_step: got %b expected 0", bus.step); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    n_cmp++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL reset_armed: got %b expected 0", bus.armed); end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    int steps;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(2'b00);
    hold(8, steps);
    n_cmp++; if (bus.armed !== 1'b1) begin n_bad++; $display("FAIL fwd_armed: got %b expected 1", bus.armed); end
    steps = 0;
    for (int k = 0; k < 4; k++) begin
      set_ab(seq[k]);
      for (int t = 1; t <= 8; t++) begin
        cycle();
        if (bus.step === 1'b1) steps++;
        if (t == 4) begin
          n_cmp++; if (bus.position !== WIDTH'(k)) begin n_bad++; $display("FAIL fwd_early_pos: got %0d expected %0d", bus.position, k); end
        end
        if (t == 5) begin
          n_cmp++; if (bus.step !== 1'b1) begin n_bad++; $display("FAIL fwd_step_latency: got %b expected 1", bus.step); end
          n_cmp++; if (bus.position !== WIDTH'(k + 1)) begin n_bad++; $display("FAIL fwd_pos: got %0d expected %0d", bus.position, k + 1); end
          n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL fwd_dir: got %b expected 0", bus.dir); end
        end
      end
    end
    n_cmp++; if (steps != 4) begin n_bad++; $display("FAIL fwd_step_count: got %0d expected 4", steps); end
  endtask

  task automatic test_wrap();
    int steps;
    do_reset(2'b00);
    hold(8, steps);
    set_ab(2'b10);
    hold(8, steps);
    n_cmp++; if (bus.position !== WIDTH'(MODV - 1)) begin n_bad++; $display("FAIL wrap_pos: got %0d expected %0d", bus.position, MODV - 1); end
    n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL wrap_dir: got %b expected 1", bus.dir); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL wrap_err: got %b expected 0", bus.err); end
    set_ab(2'b00);
    hold(8, steps);
    n_cmp++; if (bus.position !== WIDTH'(0)) begin n_bad++; $display("FAIL wrap_up_pos: got %0d expected 0", bus.position); end
  endtask

  // Entered from position 0 with inputs at 00.
  task automatic test_glitch();
    int steps;
    set_ab(2'b01);
    hold(8, steps);
    set_ab(2'b00);
    cycle();
    set_ab(2'b01);
    hold(12, steps);
    n_cmp++; if (steps != 0) begin n_bad++; $display("FAIL glitch_steps: got %0d expected 0", steps); end
    n_cmp++; if (bus.position !== WIDTH'(1)) begin n_bad++; $display("FAIL glitch_pos: got %0d expected 1", bus.position); end
    set_ab(2'b00);
    hold(8, steps);
    n_cmp++; if (bus.position !== WIDTH'(0)) begin n_bad++; $display("FAIL glitch_rev_pos: got %0d expected 0", bus.position); end
    set_ab(2'b11);
    hold(8, steps);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b expected 1", bus.err); end
    n_cmp++; if (bus.position !== WIDTH'(0)) begin n_bad++; $display("FAIL illegal_pos: got %0d expected 0", bus.position); end
    n_cmp++; if (steps != 0) begin n_bad++; $display("FAIL illegal_steps: got %0d expected 0", steps); end
  endtask

  // Entered at position 0, err=1, inputs at 11.
  task automatic test_clear();
    int steps;
    set_ab(2'b10);
    hold(4, steps);
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    n_cmp++; if (bus.position !== WIDTH'(RESET_POS)) begin n_bad++; $display("FAIL clear_pos: got %0d expected %0d", bus.position, RESET_POS); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL clear_err: got %b expected 0", bus.err); end
    n_cmp++; if (bus.step !== 1'b0) begin n_bad++; $display("FAIL clear_step: got %b expected 0", bus.step); end
    set_ab(2'b00);
    hold(8, steps);
    n_cmp++; if (bus.position !== WIDTH'(RESET_POS + 1)) begin n_bad++; $display("FAIL clear_next_pos: got %0d expected %0d", bus.position, RESET_POS + 1); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL clear_next_err: got %b expected 0", bus.err); end
  endtask

  // Entered at position 1 with inputs at 00.
  task automatic test_enable();
    int steps, total;
    total = 0;
    bus.enable = 1'b0;
    set_ab(2'b01); hold(8, steps); total += steps;
    set_ab(2'b11); hold(8, steps); total += steps;
    bus.enable = 1'b1;
    hold(8, steps); total += steps;
    n_cmp++; if (total != 0) begin n_bad++; $display("FAIL enable_steps: got %0d expected 0", total); end
    n_cmp++; if (bus.position !== WIDTH'(1)) begin n_bad++; $display("FAIL enable_hold_pos: got %0d expected 1", bus.position); end
    set_ab(2'b10);
    hold(8, steps);
    n_cmp++; if (bus.position !== WIDTH'(2)) begin n_bad++; $display("FAIL enable_next_pos: got %0d expected 2", bus.position); end
    n_cmp++; if (steps != 1) begin n_bad++; $display("FAIL enable_next_steps: got %0d expected 1", steps); end
  endtask

  // Entered at position 2 with inputs at 10; reverse step makes dir=1 first.
  task automatic test_rst_mid();
    int steps;
    set_ab(2'b11);
    hold(8, steps);
    set_ab(2'b10);
    hold(2, steps);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (bus.position !== WIDTH'(RESET_POS)) begin n_bad++; $display("FAIL rstmid_pos: got %0d expected %0d", bus.position, RESET_POS); end
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL rstmid_dir: got %b expected 0", bus.dir); end
    n_cmp++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL rstmid_armed: got %b expected 0", bus.armed); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err: got %b expected 0", bus.err); end
    @(negedge clk);
  endtask

  task automatic test_arm_11();
    int steps;
    do_reset(2'b11);
    for (int t = 1; t <= 4; t++) begin
      cycle();
      if (t == 3) begin
        n_cmp++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL arm_early: got %b expected 0", bus.armed); end
      end
    end
    n_cmp++; if (bus.armed !== 1'b1) begin n_bad++; $display("FAIL arm_set: got %b expected 1", bus.armed); end
    hold(4, steps);
    n_cmp++; if (steps != 0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL arm_quiet: got steps=%0d err=%b expected steps=0 err=0", steps, bus.err); end
    set_ab(2'b10);
    hold(8, steps);
    n_cmp++; if (bus.position !== WIDTH'(RESET_POS + 1)) begin n_bad++; $display("FAIL arm_first_pos: got %0d expected %0d", bus.position, RESET_POS + 1); end
  endtask

  task automatic test_random();
    logic [1:0] vals [4];
    int cur, r, hold_n;
    vals = '{2'b00, 2'b01, 2'b11, 2'b10};
    do_reset(2'b00);
    cur = 0;
    for (int s = 0; s < 90; s++) begin
      if (s == 45) do_reset(vals[cur]);
      r = $urandom_range(0, 9);
      if (r < 4) cur = (cur + 1) % 4;
      else if (r < 7) cur = (cur + 3) % 4;
      else if (r < 8) cur = (cur + 2) % 4;
      set_ab(vals[cur]);
      hold_n = $urandom_range(1, 10);
      bus.enable = ($urandom_range(0, 7) != 0);
      for (int t = 0; t < hold_n; t++) begin
        bus.clear = ($urandom_range(0, 24) == 0);
        cycle();
        n_cmp++; if (bus.position !== WIDTH'(m_pos)) begin n_bad++; $display("FAIL rnd_pos: got %0d expected %0d", bus.position, m_pos); end
        n_cmp++; if (bus.dir !== m_dir) begin n_bad++; $display("FAIL rnd_dir: got %b expected %b", bus.dir, m_dir); end
        n_cmp++; if (bus.step !== m_step) begin n_bad++; $display("FAIL rnd_step: got %b expected %b", bus.step, m_step); end
        n_cmp++; if (bus.err !== m_err) begin n_bad++; $display("FAIL rnd_err: got %b expected %b", bus.err, m_err); end
        n_cmp++; if (bus.armed !== m_armed) begin n_bad++; $display("FAIL rnd_armed: got %b expected %b", bus.armed, m_armed); end
      end
    end
    bus.clear  = 1'b0;
    bus.enable = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.clear  = 1'b0;
    bus.a_in   = 1'b0;
    bus.b_in   = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_forward();
    test_wrap();
    test_glitch();
    test_clear();
    test_enable();
    test_rst_mid();
    test_arm_11();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
